// File: rtl/conv_pkg.sv
// conv_pkg: types and helpers shared by the convolution sequencer, its window
// address generator and the pooling controller.
//   conv_state_t : sequencer state encoding
//   out_dim      : output map size of a valid (no padding, stride 1) convolution
//   cnt_width    : counter width for a range of n values, never less than 1 bit
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } conv_state_t;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen: nested row/col (output pixel) and ky/kx (kernel tap)
// counters plus the pixel/weight/output address arithmetic.
//   clk, rst          clock, async active-high reset
//   clear             zero all counters (start of a pass)
//   tap_step          advance to the next kernel tap; wraps after the last tap
//   pix_step          advance to the next output pixel (row-major)
//   pix_addr          (row+ky)*IMG_W + col+kx
//   wgt_addr          tap index ky*K+kx
//   out_addr          row*OUT_W + col
//   last_tap/last_pix current tap / pixel is the final one
import conv_pkg::*;

module conv_window_addr_gen #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               tap_step,
    input  logic               pix_step,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               last_tap,
    output logic               last_pix
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int ROW_W = cnt_width(OUT_H);
    localparam int COL_W = cnt_width(OUT_W);
    localparam int KC_W  = cnt_width(K);

    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic [KC_W-1:0]    ky_r;
    logic [KC_W-1:0]    kx_r;
    logic [WADDR_W-1:0] tap_r;

    logic last_kx_s;
    logic last_ky_s;
    logic last_col_s;
    logic last_row_s;

    assign last_kx_s  = (kx_r == KC_W'(K - 1));
    assign last_ky_s  = (ky_r == KC_W'(K - 1));
    assign last_col_s = (col_r == COL_W'(OUT_W - 1));
    assign last_row_s = (row_r == ROW_W'(OUT_H - 1));
    assign last_tap   = last_kx_s && last_ky_s;
    assign last_pix   = last_col_s && last_row_s;

    // Kernel tap counters; tap_r mirrors ky*K+kx so no multiplier is needed for wgt_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ky_r  <= KC_W'(0);
            kx_r  <= KC_W'(0);
            tap_r <= WADDR_W'(0);
        end else if (clear || (tap_step && last_tap)) begin
            ky_r  <= KC_W'(0);
            kx_r  <= KC_W'(0);
            tap_r <= WADDR_W'(0);
        end else if (tap_step) begin
            tap_r <= tap_r + WADDR_W'(1);
            if (last_kx_s) begin
                kx_r <= KC_W'(0);
                ky_r <= ky_r + KC_W'(1);
            end else begin
                kx_r <= kx_r + KC_W'(1);
            end
        end
    end

    // Output pixel counters, column fastest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= ROW_W'(0);
            col_r <= COL_W'(0);
        end else if (clear) begin
            row_r <= ROW_W'(0);
            col_r <= COL_W'(0);
        end else if (pix_step) begin
            if (last_col_s) begin
                col_r <= COL_W'(0);
                row_r <= last_row_s ? ROW_W'(0) : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    assign pix_addr = (ADDR_W'(row_r) + ADDR_W'(ky_r)) * ADDR_W'(IMG_W)
                    + ADDR_W'(col_r) + ADDR_W'(kx_r);
    assign wgt_addr = tap_r;
    assign out_addr = ADDR_W'(row_r) * ADDR_W'(OUT_W) + ADDR_W'(col_r);

endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: walks every valid output pixel of one feature map,
// issues the K*K taps of each window to the MAC, waits MAC_LAT cycles, hands
// the result to pooling over valid/ready, then pulses done.
//   clk, rst             clock, async active-high reset
//   start / busy / done  layer handshake (start sampled only in IDLE)
//   pix_addr, wgt_addr   pixel RAM / weight ROM read addresses (0 outside MAC)
//   mac_en/first/last    MAC control, active only in MAC
//   out_valid/ready/addr result handshake towards the pooling stage
// start is captured into start_q_r and acted on one edge later, so busy rises
// in the cycle after the accepting edge. All outputs decode registered state.
import conv_pkg::*;

module conv_layer_sequencer #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4,
    parameter int MAC_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               mac_en,
    output logic               mac_first,
    output logic               mac_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr
);

    localparam int DR_W      = cnt_width(MAC_LAT);
    localparam int DRAIN_MAX = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_chk_addr
        $error("conv_layer_sequencer: IMG_W*IMG_H does not fit in ADDR_W bits");
    end
    if (K * K > 2 ** WADDR_W) begin : g_chk_waddr
        $error("conv_layer_sequencer: K*K does not fit in WADDR_W bits");
    end
    if (K < 1 || IMG_W < K || IMG_H < K || MAC_LAT < 0) begin : g_chk_dims
        $error("conv_layer_sequencer: illegal kernel/map/latency parameters");
    end

    conv_state_t       state_r;
    conv_state_t       state_next_s;
    logic              start_q_r;
    logic [DR_W-1:0]   drain_r;

    logic              clear_s;
    logic              tap_step_s;
    logic              pix_step_s;
    logic [ADDR_W-1:0] gen_pix_addr_s;
    logic [WADDR_W-1:0] gen_wgt_addr_s;
    logic [ADDR_W-1:0] gen_out_addr_s;
    logic              last_tap_s;
    logic              last_pix_s;

    conv_window_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .K       (K),
        .ADDR_W  (ADDR_W),
        .WADDR_W (WADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .tap_step (tap_step_s),
        .pix_step (pix_step_s),
        .pix_addr (gen_pix_addr_s),
        .wgt_addr (gen_wgt_addr_s),
        .out_addr (gen_out_addr_s),
        .last_tap (last_tap_s),
        .last_pix (last_pix_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Start capture: one-shot so a held start cannot re-arm while leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q_r <= 1'b0;
        end else begin
            start_q_r <= (state_r == ST_IDLE) && start && !start_q_r;
        end
    end

    // MAC pipeline drain counter, idles at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_r <= DR_W'(0);
        end else if ((state_r == ST_DRAIN) && (drain_r != DR_W'(DRAIN_MAX))) begin
            drain_r <= drain_r + DR_W'(1);
        end else begin
            drain_r <= DR_W'(0);
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        tap_step_s   = 1'b0;
        pix_step_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_q_r) begin
                    state_next_s = ST_MAC;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                tap_step_s = 1'b1;
                if (last_tap_s) begin
                    state_next_s = (MAC_LAT > 0) ? ST_DRAIN : ST_WRITE;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DR_W'(DRAIN_MAX)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                if (out_ready) begin
                    pix_step_s   = 1'b1;
                    state_next_s = last_pix_s ? ST_DONE : ST_MAC;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_r == ST_MAC) || (state_r == ST_DRAIN) || (state_r == ST_WRITE);
    assign done      = (state_r == ST_DONE);
    assign mac_en    = (state_r == ST_MAC);
    assign mac_first = (state_r == ST_MAC) && (gen_wgt_addr_s == WADDR_W'(0));
    assign mac_last  = (state_r == ST_MAC) && last_tap_s;
    assign pix_addr  = (state_r == ST_MAC) ? gen_pix_addr_s : ADDR_W'(0);
    assign wgt_addr  = (state_r == ST_MAC) ? gen_wgt_addr_s : WADDR_W'(0);
    assign out_valid = (state_r == ST_WRITE);
    assign out_addr  = (state_r == ST_WRITE) ? gen_out_addr_s : ADDR_W'(0);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench: DUT a is 4x4/K=3/MAC_LAT=2, DUT b is 2x2/K=1/MAC_LAT=0.
module tb_conv_layer_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start, start_b, out_ready;

    logic       busy, done, mac_en, mac_first, mac_last, out_valid;
    logic [9:0] pix_addr, out_addr;
    logic [3:0] wgt_addr;

    logic       b_busy, b_done, b_mac_en, b_mac_first, b_mac_last, b_out_valid;
    logic [9:0] b_pix_addr, b_out_addr;
    logic [3:0] b_wgt_addr;

    always #5 clk = ~clk;

    conv_layer_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .ADDR_W(10), .WADDR_W(4), .MAC_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pix_addr(pix_addr), .wgt_addr(wgt_addr), .mac_en(mac_en), .mac_first(mac_first),
        .mac_last(mac_last), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr)
    );

    conv_layer_sequencer #(.IMG_W(2), .IMG_H(2), .K(1), .ADDR_W(10), .WADDR_W(4), .MAC_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
        .pix_addr(b_pix_addr), .wgt_addr(b_wgt_addr), .mac_en(b_mac_en), .mac_first(b_mac_first),
        .mac_last(b_mac_last), .out_valid(b_out_valid), .out_ready(1'b1), .out_addr(b_out_addr)
    );

    typedef struct {
        int pix;
        int wgt;
        int first;
        int last;
    } tap_vec_t;

    tap_vec_t tab[18];
    int pexp[18] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 5, 6, 7, 9, 10, 11, 13, 14, 15};

    int total = 0;
    int bad = 0;

    int tap_pix[$], tap_wgt[$], tap_first[$], tap_last[$], outs[$];
    int done_cyc, busy_cnt, done_cnt, last_cyc, valid_cyc;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic check_zero_a(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pix"}, pix_addr, 0);
        check({tag, "_wgt"}, wgt_addr, 0);
        check({tag, "_mac_en"}, mac_en, 0);
        check({tag, "_mac_first"}, mac_first, 0);
        check({tag, "_mac_last"}, mac_last, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_addr"}, out_addr, 0);
    endtask

    // One pass on dut_a; optionally stalls the given output pixel and/or holds start.
    task automatic run_a(input int stall_pix, input int stall_len, input bit hold_start);
        int stall_left;
        tap_pix.delete(); tap_wgt.delete(); tap_first.delete(); tap_last.delete(); outs.delete();
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; last_cyc = -1; valid_cyc = -1;
        stall_left = stall_len;
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        if (!hold_start) start = 1'b0;
        check("busy_at_accept", busy, 0);
        for (int n = 1; n <= 200 && done_cyc < 0; n++) begin
            tick;
            if (busy) busy_cnt++;
            if (mac_en) begin
                tap_pix.push_back(pix_addr);
                tap_wgt.push_back(wgt_addr);
                tap_first.push_back(mac_first);
                tap_last.push_back(mac_last);
            end
            if (mac_last && last_cyc < 0) last_cyc = n;
            if (out_valid && valid_cyc < 0) valid_cyc = n;
            out_ready = 1'b1;
            if (out_valid && out_addr == stall_pix && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                check("stall_mac_en", mac_en, 0);
                check("stall_busy", busy, 1);
            end
            if (out_valid && out_ready) outs.push_back(out_addr);
            if (done) begin
                done_cyc = n;
                done_cnt++;
                check("busy_in_done", busy, 0);
                start = 1'b0;
            end
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (done) done_cnt++;
        end
        check("idle_busy_after_pass", busy, 0);
    endtask

    task automatic check_pass(input string tag, input int exp_done, input int exp_busy);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_tap_count"}, tap_pix.size(), 36);
        check({tag, "_last_to_valid"}, valid_cyc - last_cyc, 3);
        check({tag, "_out_count"}, outs.size(), 4);
        for (int i = 0; i < 4; i++) check({tag, "_out_addr_seq"}, qget(outs, i), i);
        for (int i = 0; i < 18; i++) begin
            int idx;
            idx = (i < 9) ? i : i + 18;
            check({tag, "_tap_pix"}, qget(tap_pix, idx), tab[i].pix);
            check({tag, "_tap_wgt"}, qget(tap_wgt, idx), tab[i].wgt);
            check({tag, "_tap_first"}, qget(tap_first, idx), tab[i].first);
            check({tag, "_tap_last"}, qget(tap_last, idx), tab[i].last);
        end
    endtask

    initial begin
        int found;
        int b_pix[$], b_fl[$];
        int b_done_cyc;

        for (int i = 0; i < 18; i++) begin
            tab[i].pix   = pexp[i];
            tab[i].wgt   = i % 9;
            tab[i].first = (i % 9 == 0) ? 1 : 0;
            tab[i].last  = (i % 9 == 8) ? 1 : 0;
        end

        rst = 1'b1; start = 1'b0; start_b = 1'b0; out_ready = 1'b1;
        tick; tick;
        check_zero_a("reset");
        check("reset_b_busy", b_busy, 0);
        check("reset_b_mac_en", b_mac_en, 0);
        rst = 1'b0;
        tick;

        // Reset in the middle of pixel 1's MAC phase.
        start = 1'b1; tick; start = 1'b0;
        found = 0;
        for (int n = 0; n < 60 && found == 0; n++) begin
            tick;
            if (mac_en && mac_first && pix_addr == 10'd1) found = 1;
        end
        check("reach_pixel1", found, 1);
        tick; tick;
        check("mid_mac_en", mac_en, 1);
        #2 rst = 1'b1;
        #1 check_zero_a("async_rst");
        tick;
        rst = 1'b0;
        tick;
        check_zero_a("after_rst");

        // Full pass with restart from pixel 0, out_ready always high.
        run_a(-1, 0, 1'b0);
        check_pass("pass", 49, 48);

        // Backpressure of 5 cycles on output pixel 2.
        run_a(2, 5, 1'b0);
        check_pass("stall", 54, 53);

        // start held high for the whole pass.
        run_a(-1, 0, 1'b1);
        check_pass("hold", 49, 48);

        // K=1, MAC_LAT=0, 2x2 map.
        b_done_cyc = -1;
        start_b = 1'b1; tick; start_b = 1'b0;
        for (int n = 1; n <= 40 && b_done_cyc < 0; n++) begin
            tick;
            if (b_mac_en) begin
                b_pix.push_back(b_pix_addr);
                b_fl.push_back((b_mac_first && b_mac_last) ? 1 : 0);
            end
            if (b_done) b_done_cyc = n;
        end
        if (b_done_cyc < 0) check("b_done_timeout", 0, 1);
        check("b_done_cycle", b_done_cyc, 9);
        check("b_tap_count", b_pix.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("b_pix", qget(b_pix, i), i);
            check("b_first_last", qget(b_fl, i), 1);
        end
        tick;
        check("b_idle_busy", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
